// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and 1D DCT cosine coefficient generator.
// The generator is evaluated only at elaboration time to fill the cosine ROMs.
package dct_pkg;

    localparam int N     = 8;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // round(a(k)*cos((2n+1)*k*pi/16)*2^frac); a(0)=sqrt(1/8) equals cos(pi/4)/2,
    // so k=0 reuses the pi/4 entry and every case divides a Q30 cosine by two.
    function automatic int cos_coef(input int k, input int n, input int frac);
        int     m;
        bit     neg;
        longint q30;
        longint mag;
        m   = (k == 0) ? 4 : ((2 * n + 1) * k) % 32;
        neg = 1'b0;
        if (m > 16) m = 32 - m;
        if (m > 8) begin
            m   = 16 - m;
            neg = 1'b1;
        end
        case (m)
            0:       q30 = 64'sd1073741824;
            1:       q30 = 64'sd1053110176;
            2:       q30 = 64'sd992008094;
            3:       q30 = 64'sd892783698;
            4:       q30 = 64'sd759250125;
            5:       q30 = 64'sd596538995;
            6:       q30 = 64'sd410903207;
            7:       q30 = 64'sd209476638;
            default: q30 = 64'sd0;
        endcase
        mag = ((q30 <<< frac) + (64'sd1 <<< 30)) >>> 31;
        return neg ? -int'(mag) : int'(mag);
    endfunction

endpackage

// File: rtl/dct_cos1d_rom.sv
// 1D cosine lookup c[k][n]; purely combinational (0 cycles).
// No flow control: output follows k/n directly.
module dct_cos1d_rom
    import dct_pkg::*;
#(
    parameter int COS_FRAC = 8,
    parameter int COS_W    = COS_FRAC + 2
) (
    input  logic [2:0]              k,
    input  logic [2:0]              n,
    output logic signed [COS_W-1:0] entry
);

    logic signed [COS_W-1:0] rom_tbl [N*N];

    for (genvar i = 0; i < N * N; i++) begin : g_tbl
        assign rom_tbl[i] = COS_W'(cos_coef(i / N, i % N, COS_FRAC));
    end

    assign entry = rom_tbl[{k, n}];

endmodule

// File: rtl/dct_coef_mac.sv
// One 2D DCT coefficient from a 64-pixel raster block; DCT_ROUND_EN selects round-half-up output.
// Latency: result valid the cycle after the 64th pixel handshake; one pixel accepted per cycle.
// Backpressure: pix_ready only in ACCUM; result held stable in DONE until coef_ready.
module dct_coef_mac
    import dct_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int COS_FRAC = 8,
    parameter int ACC_W    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [2:0]               k1,
    input  logic [2:0]               k2,
    input  logic                     pix_valid,
    output logic                     pix_ready,
    input  logic signed [DATA_W-1:0] pix_data,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [ACC_W-1:0]  coef_data,
    output logic                     busy
);

    localparam int COS_W  = COS_FRAC + 2;
    localparam int PROD_W = DATA_W + 2 * COS_W;
    localparam int SHIFT  = 2 * COS_FRAC;

`ifdef DCT_ROUND_EN
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (SHIFT - 1);
`else
    localparam logic signed [ACC_W-1:0] RND = '0;
`endif

    state_t                   state_q, state_d;
    logic [2:0]               k1_q, k1_d, k2_q, k2_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d, coef_q, coef_d, acc_rnd;
    logic signed [COS_W-1:0]  c_row, c_col;
    logic signed [PROD_W-1:0] prod;

    dct_cos1d_rom #(.COS_FRAC(COS_FRAC), .COS_W(COS_W)) u_rom_row (
        .k     (k1_q),
        .n     (idx_q[IDX_W-1 -: 3]),
        .entry (c_row)
    );

    dct_cos1d_rom #(.COS_FRAC(COS_FRAC), .COS_W(COS_W)) u_rom_col (
        .k     (k2_q),
        .n     (idx_q[2:0]),
        .entry (c_col)
    );

    // Operands widened first so the triple product never truncates.
    assign prod = PROD_W'(pix_data) * PROD_W'(c_row) * PROD_W'(c_col);

    always_comb begin
        state_d = state_q;
        k1_d    = k1_q;
        k2_d    = k2_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        coef_d  = coef_q;
        acc_rnd = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    k1_d    = k1;
                    k2_d    = k2;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (pix_valid) begin
                    acc_d = acc_q + ACC_W'(prod);
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(N * N - 1)) begin
                        state_d = DONE;
                        acc_rnd = acc_d + RND;
                        coef_d  = acc_rnd >>> SHIFT;
                    end
                end
            end
            DONE: begin
                if (coef_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            k1_q    <= '0;
            k2_q    <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            coef_q  <= '0;
        end else begin
            state_q <= state_d;
            k1_q    <= k1_d;
            k2_q    <= k2_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            coef_q  <= coef_d;
        end
    end

    assign pix_ready  = (state_q == ACCUM);
    assign coef_valid = (state_q == DONE);
    assign busy       = (state_q != IDLE);
    assign coef_data  = coef_q;

endmodule

// File: tb/tb_dct_coef_mac.sv
// Bench for dct_coef_mac: real-valued cosine model, per-cycle output compare,
// directed block cases and randomized blocks with and without pixel gaps.
module tb_dct_coef_mac;

    localparam int DATA_W   = 8;
    localparam int COS_FRAC = 8;
    localparam int ACC_W    = 32;
    localparam int SHIFT    = 2 * COS_FRAC;
`ifdef DCT_ROUND_EN
    localparam longint EXP_DC  = 809;
    localparam longint EXP_IMP = 31;
`else
    localparam longint EXP_DC  = 808;
    localparam longint EXP_IMP = 30;
`endif

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     start = 1'b0;
    logic [2:0]               k1 = '0;
    logic [2:0]               k2 = '0;
    logic                     pix_valid = 1'b0;
    logic                     pix_ready;
    logic signed [DATA_W-1:0] pix_data = '0;
    logic                     coef_valid;
    logic                     coef_ready = 1'b0;
    logic signed [ACC_W-1:0]  coef_data;
    logic                     busy;

    dct_coef_mac #(.DATA_W(DATA_W), .COS_FRAC(COS_FRAC), .ACC_W(ACC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .k1         (k1),
        .k2         (k2),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int     n_pass = 0;
    int     n_total = 0;
    int     cos_tab [8][8];
    int     pix [64];
    bit     cmp_en = 1'b0;
    int     m_phase = 0;
    int     m_cnt = 0;
    int     m_k1 = 0;
    int     m_k2 = 0;
    longint m_acc = 0;
    longint m_result = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic longint scale_out(input longint acc);
        longint r;
        r = acc;
`ifdef DCT_ROUND_EN
        r = r + (longint'(1) <<< (SHIFT - 1));
`endif
        return r >>> SHIFT;
    endfunction

    function automatic longint block_acc(input int a, input int b);
        longint s;
        s = 0;
        for (int i = 0; i < 64; i++)
            s += longint'(pix[i]) * cos_tab[a][i / 8] * cos_tab[b][i % 8];
        return s;
    endfunction

    // Reference: 0 idle, 1 collecting pixels, 2 result offered.
    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0;
            m_cnt   = 0;
            m_acc   = 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_k1 = int'(k1); m_k2 = int'(k2);
                m_acc = 0; m_cnt = 0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (pix_valid) begin
                m_acc += longint'(pix_data) * cos_tab[m_k1][m_cnt / 8] * cos_tab[m_k2][m_cnt % 8];
                m_cnt++;
                if (m_cnt == 64) begin
                    m_phase  = 2;
                    m_result = scale_out(m_acc);
                end
            end
        end else if (coef_ready) begin
            m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pix_ready", longint'(pix_ready), longint'(m_phase == 1));
            check("coef_valid", longint'(coef_valid), longint'(m_phase == 2));
            check("busy", longint'(busy), longint'(m_phase != 0));
            if (m_phase == 2) check("coef_data", longint'(coef_data), m_result);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int a, input int b);
        start = 1'b1; k1 = 3'(a); k2 = 3'(b);
        step();
        start = 1'b0; k1 = 3'($urandom); k2 = 3'($urandom);
    endtask

    task automatic feed(input int count, input bit gaps);
        int g;
        int t;
        for (int i = 0; i < count; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 3);
                for (int j = 0; j < g; j++) begin
                    pix_valid = 1'b0; pix_data = DATA_W'($urandom);
                    step();
                end
            end
            pix_valid = 1'b1; pix_data = DATA_W'(pix[i]);
            t = 0;
            while (!pix_ready && t < 20) begin step(); t++; end
            if (!pix_ready) check("pix_ready_timeout", 0, 1);
            step();
        end
        pix_valid = 1'b0;
    endtask

    task automatic finish_block(input int hold, input bit poke, output longint res);
        int t;
        t = 0;
        while (!coef_valid && t < 5) begin step(); t++; end
        check("coef_valid_latency", t, 0);
        res = longint'(coef_data);
        for (int h = 0; h < hold; h++) begin
            if (poke && h == 2) begin start = 1'b1; k1 = 3'd1; k2 = 3'd1; end
            else start = 1'b0;
            step();
            check("hold_valid", longint'(coef_valid), 1);
            check("hold_data", longint'(coef_data), res);
        end
        coef_ready = 1'b1; start = poke;
        step();
        coef_ready = 1'b0; start = 1'b0;
        check("idle_after_hs", longint'(busy), 0);
        step();
        check("start_ignored", longint'(busy), 0);
    endtask

    initial begin
        real    a, v;
        longint r1, r2;
        int     ka, kb;
        for (int k = 0; k < 8; k++)
            for (int n = 0; n < 8; n++) begin
                a = (k == 0) ? $sqrt(1.0 / 8.0) : 0.5;
                v = a * $cos(real'((2 * n + 1) * k) * 3.14159265358979 / 16.0) * (2.0 ** COS_FRAC);
                cos_tab[k][n] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
            end

        step(); step();
        cmp_en = 1'b1;
        check("rst_busy", longint'(busy), 0);
        check("rst_pix_ready", longint'(pix_ready), 0);
        check("rst_coef_valid", longint'(coef_valid), 0);
        check("rst_coef_data", longint'(coef_data), 0);
        reset = 1'b0;

        for (int i = 0; i < 64; i++) pix[i] = 100;
        check("model_c0", cos_tab[0][5], 91);
        check("model_c1_0", cos_tab[1][0], 126);
        check("model_acc_dc", block_acc(0, 0), 52998400);
        check("model_out_dc", scale_out(block_acc(0, 0)), EXP_DC);

        // DC block
        pulse_start(0, 0);
        feed(64, 1'b0);
        check("pix_ready_drop", longint'(pix_ready), 0);
        finish_block(0, 1'b0, r1);
        check("dc_coef", r1, EXP_DC);

        // Constant block through an AC basis must cancel exactly
        for (int i = 0; i < 64; i++) pix[i] = 37;
        pulse_start(2, 7);
        feed(64, 1'b0);
        finish_block(0, 1'b0, r1);
        check("ac_const_zero", r1, 0);

        // Single impulse at pixel 0
        for (int i = 0; i < 64; i++) pix[i] = 0;
        pix[0] = 127;
        pulse_start(1, 1);
        feed(64, 1'b0);
        finish_block(0, 1'b0, r1);
        check("impulse_coef", r1, EXP_IMP);

        // Reset in the middle of accumulation
        for (int i = 0; i < 64; i++) pix[i] = 100;
        pulse_start(0, 0);
        feed(10, 1'b0);
        reset = 1'b1;
        step();
        check("midrst_busy", longint'(busy), 0);
        check("midrst_pix_ready", longint'(pix_ready), 0);
        check("midrst_coef_valid", longint'(coef_valid), 0);
        check("midrst_coef_data", longint'(coef_data), 0);
        reset = 1'b0;
        step();
        pulse_start(0, 0);
        feed(64, 1'b0);
        finish_block(0, 1'b0, r1);
        check("dc_after_reset", r1, EXP_DC);

        // Result held under backpressure with start pokes in DONE
        pulse_start(0, 0);
        feed(64, 1'b0);
        finish_block(5, 1'b1, r1);
        check("dc_held", r1, EXP_DC);

        // Random blocks, gap-free then gapped
        for (int it = 0; it < 4; it++) begin
            for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 255)) - 128;
            ka = $urandom_range(0, 7);
            kb = $urandom_range(0, 7);
            pulse_start(ka, kb);
            feed(64, 1'b0);
            finish_block(0, 1'b0, r1);
            check("rand_model", r1, scale_out(block_acc(ka, kb)));
            pulse_start(ka, kb);
            feed(64, 1'b1);
            check("gap_pix_ready_drop", longint'(pix_ready), 0);
            finish_block(0, 1'b0, r2);
            check("gap_match", r2, r1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
